tm_poll_resp_buf: RTL and testbench
===================================

// Module: tm_poll_resp_buf
// PURPOSE
//  Downstream of the TM queue-association lookup stage. Pairs each ASA poll request (qid) with its in-order
//  association result (conn/conn-group/port-queue/port ids) and buffers the merged response.
//  Returns the response to ASA over a valid/ready handshake; issues a poll credit so outstanding polls never exceed DEPTH.
// PARAMETERS
//  DEPTH        8  max outstanding polls = tag FIFO depth = response FIFO depth (power of 2, >=2)
//  DEPTH_NBITS  3  log2(DEPTH)
// PORTS
//  clk                        in   1   clock
//  `RESET_SIG                 in   1   reset, asynchronous, active-high
//  asa_tm_poll_req            in   1   poll request from ASA (same strobe fed to association lookup)
//  asa_tm_poll_qid            in   `FIRST_LVL_QUEUE_ID_NBITS   polled first-level qid
//  poll_association_ack       in   1   association result valid (in request order)
//  association_conn_id        in   `SECOND_LVL_QUEUE_ID_NBITS  result: connection id
//  association_conn_group_id  in   `THIRD_LVL_QUEUE_ID_NBITS   result: connection-group id
//  association_port_queue_id  in   `FOURTH_LVL_QUEUE_ID_NBITS  result: port queue id
//  association_port_id        in   `PORT_ID_NBITS              result: port id
//  asa_tm_poll_resp_ready     in   1   ASA accepts response this cycle
//  tm_asa_poll_resp_valid     out  1   response valid
//  tm_asa_poll_resp_qid       out  `FIRST_LVL_QUEUE_ID_NBITS   qid of response
//  tm_asa_poll_resp_conn_id / _conn_group_id / _port_queue_id / _port_id  out  widths as inputs above
//  tm_asa_poll_credit         out  1   1 = a new poll may be issued this cycle
//  poll_outstanding           out  DEPTH_NBITS+1  polls accepted and not yet handed to ASA
//  err_req_overflow           out  1   sticky: request seen with credit=0
//  err_unexpected_ack         out  1   sticky: ack seen with tag FIFO empty
// BEHAVIOUR
//  - Reset: all outputs 0, both FIFOs empty, count 0; sticky errors cleared only by reset. Reset mid-operation
//    discards all in-flight tags/responses; tm_asa_poll_credit asserts on first clk edge after reset release.
//  - tm_asa_poll_credit = (poll_outstanding != DEPTH); decoded from registered count only, no input paths.
//  - Request: if credit=1 push qid to tag FIFO, count+1. If credit=0: drop, no state change, set err_req_overflow.
//  - Ack: if tag FIFO non-empty pop head qid, push {qid, 4 ids} to response FIFO (ids sampled same cycle).
//    If tag FIFO empty (incl. req in same cycle; new tag not visible until next cycle): drop, set err_unexpected_ack.
//  - Simultaneous req + ack with non-empty tag FIFO: push and pop both occur; order preserved.
//  - Response FIFO cannot overflow: count reserves its slot at request time (tags+responses <= DEPTH).
//  - Output stage: registered, first-word-fall-through. valid/data load from response FIFO head when stage
//    empty or (valid & ready). Data held stable while valid=1 and ready=0.
//  - Handshake: transfer when valid & ready; count-1 on that cycle. Req+transfer same cycle: count unchanged.
//  - Latency: ack at cycle N with output stage idle -> tm_asa_poll_resp_valid=1 at N+1. Back-to-back transfers
//    at 1/cycle with ready held high.
//  - Responses strictly in request order; no reordering, no timeout.
//  - Pointers DEPTH_NBITS wide, wrap modulo DEPTH; full/empty from separate occupancy counters.
// TESTING
//  1. Single poll: req qid=0x15, ack 3 cyc later conn=7,port=2, ready=1 -> valid at ack+1, qid 0x15, conn 7, port 2; count 1->0.
//  2. Fill: 8 reqs back-to-back, no acks -> credit 0 after 8th; 9th req dropped, err_req_overflow=1, count stays 8.
//  3. Backpressure: 4 polls acked, ready=0 for 10 cyc -> valid held, data = first qid; ready=1 -> 4 responses on
//     4 consecutive cycles, in request order.
//  4. Unexpected ack with empty tag FIFO -> no response, err_unexpected_ack=1, count unchanged.
//  5. Steady state: req+ack+transfer every cycle for 50 cycles, qids 0..49 -> count constant, qids in order,
//     pointers wrap cleanly past DEPTH.
//  6. Assert reset with 5 outstanding and valid=1 -> all outputs 0 immediately (async); after release credit=1, count=0.

Source files
------------

// File: rtl/tm_poll_resp_buf_if.sv
// Bundle of the ASA poll request, association result and poll response signals
// seen by tm_poll_resp_buf; the slave modport is the buffer's view.
interface tm_poll_resp_buf_if #(
    parameter int DEPTH_NBITS = 3,
    parameter int QID_W       = 8,
    parameter int CONN_W      = 8,
    parameter int CGRP_W      = 6,
    parameter int PQ_W        = 6,
    parameter int PORT_W      = 4
);
    logic                   asa_tm_poll_req;
    logic [QID_W-1:0]       asa_tm_poll_qid;
    logic                   poll_association_ack;
    logic [CONN_W-1:0]      association_conn_id;
    logic [CGRP_W-1:0]      association_conn_group_id;
    logic [PQ_W-1:0]        association_port_queue_id;
    logic [PORT_W-1:0]      association_port_id;
    logic                   asa_tm_poll_resp_ready;
    logic                   tm_asa_poll_resp_valid;
    logic [QID_W-1:0]       tm_asa_poll_resp_qid;
    logic [CONN_W-1:0]      tm_asa_poll_resp_conn_id;
    logic [CGRP_W-1:0]      tm_asa_poll_resp_conn_group_id;
    logic [PQ_W-1:0]        tm_asa_poll_resp_port_queue_id;
    logic [PORT_W-1:0]      tm_asa_poll_resp_port_id;
    logic                   tm_asa_poll_credit;
    logic [DEPTH_NBITS:0]   poll_outstanding;
    logic                   err_req_overflow;
    logic                   err_unexpected_ack;

    modport master (
        output asa_tm_poll_req, asa_tm_poll_qid, poll_association_ack,
               association_conn_id, association_conn_group_id,
               association_port_queue_id, association_port_id,
               asa_tm_poll_resp_ready,
        input  tm_asa_poll_resp_valid, tm_asa_poll_resp_qid, tm_asa_poll_resp_conn_id,
               tm_asa_poll_resp_conn_group_id, tm_asa_poll_resp_port_queue_id,
               tm_asa_poll_resp_port_id, tm_asa_poll_credit, poll_outstanding,
               err_req_overflow, err_unexpected_ack
    );

    modport slave (
        input  asa_tm_poll_req, asa_tm_poll_qid, poll_association_ack,
               association_conn_id, association_conn_group_id,
               association_port_queue_id, association_port_id,
               asa_tm_poll_resp_ready,
        output tm_asa_poll_resp_valid, tm_asa_poll_resp_qid, tm_asa_poll_resp_conn_id,
               tm_asa_poll_resp_conn_group_id, tm_asa_poll_resp_port_queue_id,
               tm_asa_poll_resp_port_id, tm_asa_poll_credit, poll_outstanding,
               err_req_overflow, err_unexpected_ack
    );
endinterface

// File: rtl/tm_poll_resp_buf.sv
// Pairs ASA poll qids with in-order association results, buffers the merged
// responses and returns them over valid/ready with credit-based flow control.
module tm_poll_resp_buf #(
    parameter int DEPTH       = 8,
    parameter int DEPTH_NBITS = 3,
    parameter int QID_W       = 8,
    parameter int CONN_W      = 8,
    parameter int CGRP_W      = 6,
    parameter int PQ_W        = 6,
    parameter int PORT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    tm_poll_resp_buf_if.slave   bus
);
    typedef struct packed {
        logic [QID_W-1:0]  qid;
        logic [CONN_W-1:0] conn;
        logic [CGRP_W-1:0] cgrp;
        logic [PQ_W-1:0]   pq;
        logic [PORT_W-1:0] port;
    } resp_t;

    localparam logic [DEPTH_NBITS:0] FULL_CNT = (DEPTH_NBITS+1)'(DEPTH);

    logic [QID_W-1:0]       tag_mem_q [DEPTH];
    resp_t                  resp_mem_q [DEPTH];
    logic [DEPTH_NBITS-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [DEPTH_NBITS-1:0] resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
    logic [DEPTH_NBITS:0]   tag_cnt_q, tag_cnt_d, resp_cnt_q, resp_cnt_d;
    logic [DEPTH_NBITS:0]   cnt_q, cnt_d;
    logic                   out_vld_q, out_vld_d;
    resp_t                  out_data_q, out_data_d;
    logic                   credit_q, credit_d;
    logic                   err_ovf_q, err_ovf_d, err_ack_q, err_ack_d;

    logic  req_acc, ack_acc, xfer, load, resp_pop, bypass, resp_push;
    resp_t ack_word;

    assign req_acc   = bus.asa_tm_poll_req & credit_q;
    assign ack_acc   = bus.poll_association_ack & (tag_cnt_q != '0);
    assign xfer      = out_vld_q & bus.asa_tm_poll_resp_ready;
    assign load      = ~out_vld_q | bus.asa_tm_poll_resp_ready;
    assign resp_pop  = load & (resp_cnt_q != '0);
    // An ack goes straight to the output stage when nothing older is queued,
    // giving one-cycle ack-to-valid latency without reordering.
    assign bypass    = load & (resp_cnt_q == '0) & ack_acc;
    assign resp_push = ack_acc & ~bypass;

    assign ack_word = '{qid:  tag_mem_q[tag_rd_q],
                        conn: bus.association_conn_id,
                        cgrp: bus.association_conn_group_id,
                        pq:   bus.association_port_queue_id,
                        port: bus.association_port_id};

    always_comb begin
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        resp_wr_d  = resp_wr_q;
        resp_rd_d  = resp_rd_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        err_ovf_d  = err_ovf_q | (bus.asa_tm_poll_req & ~credit_q);
        err_ack_d  = err_ack_q | (bus.poll_association_ack & (tag_cnt_q == '0));

        tag_cnt_d  = tag_cnt_q + (DEPTH_NBITS+1)'(req_acc) - (DEPTH_NBITS+1)'(ack_acc);
        resp_cnt_d = resp_cnt_q + (DEPTH_NBITS+1)'(resp_push) - (DEPTH_NBITS+1)'(resp_pop);
        // Outstanding counts a poll from acceptance until ASA takes its response,
        // which also reserves its response FIFO slot.
        cnt_d      = cnt_q + (DEPTH_NBITS+1)'(req_acc) - (DEPTH_NBITS+1)'(xfer);
        credit_d   = (cnt_d != FULL_CNT);

        if (req_acc)   tag_wr_d  = tag_wr_q + 1'b1;
        if (ack_acc)   tag_rd_d  = tag_rd_q + 1'b1;
        if (resp_push) resp_wr_d = resp_wr_q + 1'b1;
        if (resp_pop)  resp_rd_d = resp_rd_q + 1'b1;

        if (load) begin
            if (resp_pop) begin
                out_vld_d  = 1'b1;
                out_data_d = resp_mem_q[resp_rd_q];
            end else if (bypass) begin
                out_vld_d  = 1'b1;
                out_data_d = ack_word;
            end else begin
                out_vld_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            resp_wr_q  <= '0;
            resp_rd_q  <= '0;
            resp_cnt_q <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            credit_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_ack_q  <= 1'b0;
        end else begin
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_cnt_q  <= tag_cnt_d;
            resp_wr_q  <= resp_wr_d;
            resp_rd_q  <= resp_rd_d;
            resp_cnt_q <= resp_cnt_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            credit_q   <= credit_d;
            err_ovf_q  <= err_ovf_d;
            err_ack_q  <= err_ack_d;
        end
    end

    // Storage arrays need no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (req_acc)   tag_mem_q[tag_wr_q]   <= bus.asa_tm_poll_qid;
        if (resp_push) resp_mem_q[resp_wr_q] <= ack_word;
    end

    assign bus.tm_asa_poll_resp_valid         = out_vld_q;
    assign bus.tm_asa_poll_resp_qid           = out_data_q.qid;
    assign bus.tm_asa_poll_resp_conn_id       = out_data_q.conn;
    assign bus.tm_asa_poll_resp_conn_group_id = out_data_q.cgrp;
    assign bus.tm_asa_poll_resp_port_queue_id = out_data_q.pq;
    assign bus.tm_asa_poll_resp_port_id       = out_data_q.port;
    assign bus.tm_asa_poll_credit             = credit_q;
    assign bus.poll_outstanding               = cnt_q;
    assign bus.err_req_overflow               = err_ovf_q;
    assign bus.err_unexpected_ack             = err_ack_q;
endmodule

// File: tb/tb_tm_poll_resp_buf.sv
// Directed bench for tm_poll_resp_buf: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_tm_poll_resp_buf;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [7:0] qid;
        logic [7:0] conn;
        logic [5:0] cgrp;
        logic [5:0] pq;
        logic [3:0] port;
    } mresp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    tm_poll_resp_buf_if bus ();

    tm_poll_resp_buf #(.DEPTH(DEPTH), .DEPTH_NBITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending tags, visible responses, counters.
    logic [7:0] m_tagq[$];
    mresp_t     m_respq[$];
    int         m_cnt;
    bit         m_credit, m_eovf, m_eack;
    bit         m_req_acc, m_xfer;
    mresp_t     m_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tagq.delete();
            m_respq.delete();
            m_cnt    = 0;
            m_credit = 0;
            m_eovf   = 0;
            m_eack   = 0;
        end else begin
            m_req_acc = bus.asa_tm_poll_req && m_credit;
            if (bus.asa_tm_poll_req && !m_credit) m_eovf = 1;
            m_xfer = (m_respq.size() != 0) && bus.asa_tm_poll_resp_ready;
            if (m_xfer) void'(m_respq.pop_front());
            if (bus.poll_association_ack) begin
                if (m_tagq.size() != 0) begin
                    m_r.qid  = m_tagq.pop_front();
                    m_r.conn = bus.association_conn_id;
                    m_r.cgrp = bus.association_conn_group_id;
                    m_r.pq   = bus.association_port_queue_id;
                    m_r.port = bus.association_port_id;
                    m_respq.push_back(m_r);
                end else begin
                    m_eack = 1;
                end
            end
            if (m_req_acc) m_tagq.push_back(bus.asa_tm_poll_qid);
            m_cnt    = m_cnt + int'(m_req_acc) - int'(m_xfer);
            m_credit = (m_cnt != DEPTH);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    bit ss_mode = 0;
    int ss_next = 0;

    always @(negedge clk) begin
        chk("m_valid", 32'(bus.tm_asa_poll_resp_valid), 32'(m_respq.size() != 0));
        chk("m_credit", 32'(bus.tm_asa_poll_credit), 32'(m_credit));
        chk("m_outstanding", 32'(bus.poll_outstanding), 32'(m_cnt));
        chk("m_err_ovf", 32'(bus.err_req_overflow), 32'(m_eovf));
        chk("m_err_ack", 32'(bus.err_unexpected_ack), 32'(m_eack));
        if (m_respq.size() != 0) begin
            chk("m_qid", 32'(bus.tm_asa_poll_resp_qid), 32'(m_respq[0].qid));
            chk("m_conn", 32'(bus.tm_asa_poll_resp_conn_id), 32'(m_respq[0].conn));
            chk("m_cgrp", 32'(bus.tm_asa_poll_resp_conn_group_id), 32'(m_respq[0].cgrp));
            chk("m_pq", 32'(bus.tm_asa_poll_resp_port_queue_id), 32'(m_respq[0].pq));
            chk("m_port", 32'(bus.tm_asa_poll_resp_port_id), 32'(m_respq[0].port));
        end
        if (ss_mode && bus.tm_asa_poll_resp_valid && bus.asa_tm_poll_resp_ready) begin
            chk("ss_order", 32'(bus.tm_asa_poll_resp_qid), 32'(ss_next));
            ss_next++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ack(input bit a, input logic [7:0] conn, input logic [5:0] cg,
                           input logic [5:0] pq, input logic [3:0] port);
        bus.poll_association_ack      = a;
        bus.association_conn_id       = conn;
        bus.association_conn_group_id = cg;
        bus.association_port_queue_id = pq;
        bus.association_port_id       = port;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        bus.asa_tm_poll_req        = 0;
        bus.asa_tm_poll_qid        = 0;
        bus.asa_tm_poll_resp_ready = 0;
        set_ack(0, 0, 0, 0, 0);
        do_reset();

        // Reset state, credit comes up on the first edge after release
        chk("rst_credit", 32'(bus.tm_asa_poll_credit), 0);
        chk("rst_valid", 32'(bus.tm_asa_poll_resp_valid), 0);
        chk("rst_count", 32'(bus.poll_outstanding), 0);
        tick();
        chk("rel_credit", 32'(bus.tm_asa_poll_credit), 1);

        // 1. Single poll
        bus.asa_tm_poll_req = 1; bus.asa_tm_poll_qid = 8'h15;
        tick();
        bus.asa_tm_poll_req = 0;
        chk("t1_count1", 32'(bus.poll_outstanding), 1);
        tick(); tick();
        set_ack(1, 8'd7, 6'd3, 6'd5, 4'd2);
        bus.asa_tm_poll_resp_ready = 1;
        tick();
        set_ack(0, 0, 0, 0, 0);
        chk("t1_valid", 32'(bus.tm_asa_poll_resp_valid), 1);
        chk("t1_qid", 32'(bus.tm_asa_poll_resp_qid), 32'h15);
        chk("t1_conn", 32'(bus.tm_asa_poll_resp_conn_id), 7);
        chk("t1_port", 32'(bus.tm_asa_poll_resp_port_id), 2);
        tick();
        chk("t1_count0", 32'(bus.poll_outstanding), 0);
        chk("t1_valid0", 32'(bus.tm_asa_poll_resp_valid), 0);

        // 2. Fill to DEPTH, then one dropped request
        bus.asa_tm_poll_resp_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.asa_tm_poll_req = 1; bus.asa_tm_poll_qid = 8'(8'h20 + i);
            tick();
        end
        chk("t2_credit0", 32'(bus.tm_asa_poll_credit), 0);
        chk("t2_count8", 32'(bus.poll_outstanding), 8);
        bus.asa_tm_poll_qid = 8'h99;
        tick();
        bus.asa_tm_poll_req = 0;
        chk("t2_ovf", 32'(bus.err_req_overflow), 1);
        chk("t2_count_hold", 32'(bus.poll_outstanding), 8);
        bus.asa_tm_poll_resp_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            set_ack(1, 8'(i), 6'(i + 1), 6'(i + 2), 4'(i));
            tick();
        end
        set_ack(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("t2_drained", 32'(bus.poll_outstanding), 0);

        // 3. Backpressure with four responses queued
        bus.asa_tm_poll_resp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            bus.asa_tm_poll_req = 1; bus.asa_tm_poll_qid = 8'(8'h30 + i);
            tick();
        end
        bus.asa_tm_poll_req = 0;
        for (int i = 0; i < 4; i++) begin
            set_ack(1, 8'(8'h40 + i), 6'(i), 6'(i), 4'(i));
            tick();
        end
        set_ack(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 32'(bus.tm_asa_poll_resp_valid), 1);
            chk("t3_hold_qid", 32'(bus.tm_asa_poll_resp_qid), 32'h30);
            tick();
        end
        bus.asa_tm_poll_resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_burst_valid", 32'(bus.tm_asa_poll_resp_valid), 1);
            chk("t3_burst_qid", 32'(bus.tm_asa_poll_resp_qid), 32'(8'h30 + i));
            chk("t3_burst_conn", 32'(bus.tm_asa_poll_resp_conn_id), 32'(8'h40 + i));
            tick();
        end
        chk("t3_empty", 32'(bus.tm_asa_poll_resp_valid), 0);
        chk("t3_count0", 32'(bus.poll_outstanding), 0);

        // 4. Unexpected ack
        chk("t4_err_before", 32'(bus.err_unexpected_ack), 0);
        set_ack(1, 8'h5a, 6'd1, 6'd1, 4'd1);
        tick();
        set_ack(0, 0, 0, 0, 0);
        chk("t4_err", 32'(bus.err_unexpected_ack), 1);
        chk("t4_count", 32'(bus.poll_outstanding), 0);
        tick();
        chk("t4_no_resp", 32'(bus.tm_asa_poll_resp_valid), 0);

        // 5. Steady state, one poll in and one response out per cycle
        do_reset();
        chk("t5_err_cleared", 32'(bus.err_unexpected_ack), 0);
        tick();
        bus.asa_tm_poll_resp_ready = 1;
        ss_next = 0;
        ss_mode = 1;
        for (int i = 0; i < 50; i++) begin
            bus.asa_tm_poll_req = 1; bus.asa_tm_poll_qid = 8'(i);
            set_ack(i > 0, 8'(i), 6'(i), 6'(i), 4'(i));
            tick();
            if (i >= 1) chk("t5_count_const", 32'(bus.poll_outstanding), 2);
        end
        bus.asa_tm_poll_req = 0;
        set_ack(1, 8'd50, 6'd50, 6'd50, 4'd2);
        tick();
        set_ack(0, 0, 0, 0, 0);
        repeat (3) tick();
        ss_mode = 0;
        chk("t5_all_out", 32'(ss_next), 50);
        chk("t5_count0", 32'(bus.poll_outstanding), 0);

        // 6. Asynchronous reset with work in flight
        bus.asa_tm_poll_resp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            bus.asa_tm_poll_req = 1; bus.asa_tm_poll_qid = 8'(8'h60 + i);
            tick();
        end
        bus.asa_tm_poll_req = 0;
        set_ack(1, 8'h11, 6'd2, 6'd3, 4'd4);
        tick();
        set_ack(0, 0, 0, 0, 0);
        chk("t6_valid_pre", 32'(bus.tm_asa_poll_resp_valid), 1);
        chk("t6_count_pre", 32'(bus.poll_outstanding), 5);
        #1 rst = 1'b1;
        #1;
        chk("t6_valid_rst", 32'(bus.tm_asa_poll_resp_valid), 0);
        chk("t6_qid_rst", 32'(bus.tm_asa_poll_resp_qid), 0);
        chk("t6_count_rst", 32'(bus.poll_outstanding), 0);
        chk("t6_credit_rst", 32'(bus.tm_asa_poll_credit), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_credit_rel", 32'(bus.tm_asa_poll_credit), 0);
        tick();
        chk("t6_credit_edge", 32'(bus.tm_asa_poll_credit), 1);
        chk("t6_count_edge", 32'(bus.poll_outstanding), 0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
